// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter and instruction-fetch sequencer.
// Ports:
//   Clk/Reset       clock and synchronous active-high reset
//   PCAddResult     PC+4 from the external adder (derived from PCResult)
//   Stall           decode not ready; the held instruction is kept
//   Jump/JumpTarget, BranchTaken/BranchTarget  one-cycle redirect pulses
//   IMemAck/IMemData  instruction memory response
//   PCResult/IMemAddr current PC and fetch address (always equal)
//   IMemReq         fetch request, high while waiting for the ack
//   Instruction/InstrValid  fetched word and its valid flag
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCAddResult,
   input  logic        Stall,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] PCResult,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   output logic [31:0] Instruction,
   output logic        InstrValid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic        req_q;
   logic        pend_vld_q;
   logic [31:0] pend_tgt_q;

   logic        redir;
   logic [31:0] redir_tgt;

   // Jump outranks a taken branch; targets are word aligned on load.
   always_comb begin
      redir     = Jump | BranchTaken;
      redir_tgt = Jump ? JumpTarget : BranchTarget;
      redir_tgt[1:0] = 2'b00;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0;
         valid_q    <= 1'b0;
         req_q      <= 1'b0;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (redir) begin
                  pc_q <= redir_tgt;
               end
               state_q <= S_REQ;
               req_q   <= 1'b1;
            end

            S_REQ: begin
               if (!IMemAck) begin
                  // Fetch in flight: keep the address, remember the
                  // newest redirect for when the ack arrives.
                  if (redir) begin
                     pend_vld_q <= 1'b1;
                     pend_tgt_q <= redir_tgt;
                  end
               end else if (redir) begin
                  // Returned word is stale; refetch at the new target.
                  pc_q       <= redir_tgt;
                  pend_vld_q <= 1'b0;
               end else if (pend_vld_q) begin
                  pc_q       <= pend_tgt_q;
                  pend_vld_q <= 1'b0;
               end else begin
                  instr_q <= IMemData;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= S_HOLD;
               end
            end

            S_HOLD: begin
               if (redir) begin
                  pc_q    <= redir_tgt;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end else if (!Stall) begin
                  pc_q    <= PCAddResult;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end

            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign PCResult    = pc_q;
   assign IMemAddr    = pc_q;
   assign IMemReq     = req_q;
   assign Instruction = instr_q;
   assign InstrValid  = valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and randomized bench for pc_fetch_ctrl.
// Expected deliveries come from a next-fetch-address model.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        Clk;
   logic        Reset;
   logic [31:0] PCAddResult;
   logic        Stall;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        IMemAck;
   logic [31:0] IMemData;
   logic [31:0] PCResult;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic [31:0] Instruction;
   logic        InstrValid;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .PCAddResult  (PCAddResult),
      .Stall        (Stall),
      .Jump         (Jump),
      .JumpTarget   (JumpTarget),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .IMemAck      (IMemAck),
      .IMemData     (IMemData),
      .PCResult     (PCResult),
      .IMemReq      (IMemReq),
      .IMemAddr     (IMemAddr),
      .Instruction  (Instruction),
      .InstrValid   (InstrValid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_pc;
   int          n_chk;
   int          n_pass;
   int          n_deliv;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h2008_0005;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, act, req);
   endtask

   // The next word delivered must come from the latest redirect
   // target, the reset PC, or the word after the one consumed.
   task automatic set_exp(input logic [31:0] a);
      exp_pc = a;
      exp_q.delete();
      exp_q.push_back('{pc: a, ins: memf(a)});
   endtask

   task automatic cycle(input bit rst, input bit st, input bit j,
                        input logic [31:0] jt, input bit b,
                        input logic [31:0] bt, input int ackm);
      logic ack;
      @(negedge Clk);
      Reset        = rst;
      Stall        = st;
      Jump         = j;
      JumpTarget   = jt;
      BranchTaken  = b;
      BranchTarget = bt;
      PCAddResult  = PCResult + 32'd4;
      case (ackm)
         0:       ack = 1'b0;
         1:       ack = IMemReq;
         2:       ack = IMemReq ? ($urandom_range(0, 1) == 1)
                                : ($urandom_range(0, 3) == 0);
         default: ack = 1'b1;
      endcase
      IMemAck  = ack;
      IMemData = (ack && IMemReq) ? memf(IMemAddr) : $urandom();
      if (rst)
         set_exp(RST_PC);
      else if (j)
         set_exp(jt & 32'hFFFF_FFFC);
      else if (b)
         set_exp(bt & 32'hFFFF_FFFC);
      else if (InstrValid && !st)
         set_exp(exp_pc + 32'd4);
      @(posedge Clk);
      #2;
   endtask

   task automatic outs(input string nm, input logic [31:0] pc,
                       input bit v, input bit r);
      chk({nm, "_pc"}, PCResult, pc);
      chk({nm, "_valid"}, 32'(InstrValid), 32'(v));
      chk({nm, "_req"}, 32'(IMemReq), 32'(r));
   endtask

   function automatic logic [31:0] rand_tgt();
      logic [31:0] r;
      r = $urandom();
      if ($urandom_range(0, 7) == 0) r = r | 32'hFFFF_FFF0;
      return r;
   endfunction

   // Monitor: protocol rules each cycle, scoreboard on each delivery.
   logic        have_pre;
   logic        p_req, p_valid;
   logic [31:0] p_addr, p_pc, p_ins;
   logic        i_rst, i_st, i_redir, i_ack;

   initial begin
      exp_t e;
      have_pre = 1'b0;
      forever begin
         @(posedge Clk);
         i_rst   = Reset;
         i_st    = Stall;
         i_redir = Jump | BranchTaken;
         i_ack   = IMemAck;
         #1;
         chk("addr_eq_pc", IMemAddr, PCResult);
         if (have_pre) begin
            if (i_rst) begin
               chk("rst_pc", PCResult, RST_PC);
               chk("rst_req", 32'(IMemReq), 32'd0);
               chk("rst_valid", 32'(InstrValid), 32'd0);
               chk("rst_instr", Instruction, 32'd0);
            end else if (p_req) begin
               if (!i_ack) begin
                  chk("wait_req", 32'(IMemReq), 32'd1);
                  chk("wait_addr", IMemAddr, p_addr);
               end
            end else if (p_valid) begin
               if (i_st && !i_redir) begin
                  chk("stall_pc", PCResult, p_pc);
                  chk("stall_instr", Instruction, p_ins);
                  chk("stall_valid", 32'(InstrValid), 32'd1);
                  chk("stall_req", 32'(IMemReq), 32'd0);
               end else begin
                  chk("leave_valid", 32'(InstrValid), 32'd0);
                  chk("leave_req", 32'(IMemReq), 32'd1);
               end
            end else begin
               chk("idle_req", 32'(IMemReq), 32'd1);
               chk("idle_valid", 32'(InstrValid), 32'd0);
            end
            if (!i_rst && InstrValid && !p_valid) begin
               n_deliv++;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_delivery: pc %h instr %h, none required",
                           PCResult, Instruction);
               end else begin
                  e = exp_q.pop_front();
                  chk("deliv_pc", PCResult, e.pc);
                  chk("deliv_instr", Instruction, e.ins);
               end
            end
         end
         p_req    = IMemReq;
         p_valid  = InstrValid;
         p_addr   = IMemAddr;
         p_pc     = PCResult;
         p_ins    = Instruction;
         have_pre = 1'b1;
      end
   end

   initial begin
      n_chk = 0; n_pass = 0; n_deliv = 0;
      exp_pc = RST_PC;
      Reset = 1'b1; Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
      JumpTarget = 32'h0; BranchTarget = 32'h0; PCAddResult = 32'h4;
      IMemAck = 1'b0; IMemData = 32'h0;

      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      outs("reset", RST_PC, 0, 0);
      chk("reset_instr", Instruction, 32'h0);

      // Straight-line fetch: 0, 4, 8.
      cycle(0, 0, 0, 0, 0, 0, 0);
      outs("idle2req", 32'h0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      outs("fetch0", 32'h0, 1, 0);
      chk("fetch0_instr", Instruction, 32'h2008_0005);
      cycle(0, 0, 0, 0, 0, 0, 0);
      outs("consume0", 32'h4, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk("fetch4_instr", Instruction, memf(32'h4));
      cycle(0, 0, 0, 0, 0, 0, 0);
      outs("consume4", 32'h8, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // Stall for three cycles with a stray ack.
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0, 0, 0, 3);
         outs("stall", 32'h8, 1, 0);
         chk("stall_ins", Instruction, memf(32'h8));
      end
      cycle(0, 0, 0, 0, 0, 0, 0);
      outs("unstall", 32'hC, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);

      // Jump and branch together while stalled in HOLD.
      cycle(0, 1, 1, 32'h0000_0403, 1, 32'h0000_0800, 0);
      outs("jump_prio", 32'h400, 0, 1);

      // Redirect coinciding with an ack discards the data.
      cycle(0, 0, 1, 32'h0000_0012, 0, 0, 1);
      outs("redir_ack", 32'h10, 0, 1);

      // Branch while the fetch at 0x10 is still outstanding.
      cycle(0, 0, 0, 0, 1, 32'h0000_0040, 0);
      outs("pend1", 32'h10, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      outs("pend2", 32'h10, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      outs("pend_load", 32'h40, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      outs("fetch40", 32'h40, 1, 0);
      chk("fetch40_instr", Instruction, memf(32'h40));

      // Wrap from the top of the address space.
      cycle(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
      outs("to_top", 32'hFFFF_FFFC, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0);
      outs("wrap", 32'h0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      chk("wrap_instr", Instruction, memf(32'h0));
      cycle(0, 0, 0, 0, 0, 0, 0);

      // Reset beats a same-cycle ack; a late ack in IDLE is ignored.
      cycle(1, 0, 0, 0, 0, 0, 1);
      outs("rst_ack", RST_PC, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 3);
      outs("rst_release", RST_PC, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 1);
      outs("rst_refetch", RST_PC, 1, 0);

      // Randomized traffic.
      n_deliv = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 63) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 15) == 0, rand_tgt(),
               $urandom_range(0, 11) == 0, rand_tgt(), 2);
      end
      chk("random_progress", 32'(n_deliv > 100), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 PCAddResult  input  32  PC+4 returned by the external PC adder, computed from PCResult.
REQ-005 Stall  input  1  decode not ready; a held instruction is not consumed.
REQ-006 Jump  input  1  jump redirect request, one-cycle pulse.
REQ-007 JumpTarget  input  32  jump destination; valid when Jump=1.
REQ-008 BranchTaken  input  1  taken-branch redirect request, one-cycle pulse.
REQ-009 BranchTarget  input  32  branch destination; valid when BranchTaken=1.
REQ-010 IMemAck  input  1  instruction memory has returned data this cycle.
REQ-011 IMemData  input  32  instruction word; valid when IMemAck=1.
REQ-012 PCResult  output  32  current PC; drives the adder and IMemAddr.
REQ-013 IMemReq  output  1  fetch request to instruction memory.
REQ-014 IMemAddr  output  32  fetch address; always equals PCResult.
REQ-015 Instruction  output  32  fetched instruction word.
REQ-016 InstrValid  output  1  Instruction holds a valid word for PCResult.

Function
REQ-017 FSM states: IDLE, REQ, HOLD; IDLE always transitions to REQ on the next cycle.
REQ-018 REQ: IMemReq=1; IMemAddr is held stable until IMemAck is sampled high.
REQ-019 REQ with IMemAck=1 and no redirect active or pending: Instruction<=IMemData, InstrValid<=1, next state HOLD; fetch latency is one cycle minimum from IMemReq rising.
REQ-020 HOLD: IMemReq=0, InstrValid=1; with Stall=1 and no redirect, all outputs hold.
REQ-021 HOLD with Stall=0 and no redirect: PCResult<=PCAddResult, InstrValid<=0, next state REQ.
REQ-022 Redirect priority: Jump over BranchTaken over PCAddResult; a redirect target has bits [1:0] forced to 2'b00 when loaded.
REQ-023 Redirect in HOLD, regardless of Stall: held instruction dropped, InstrValid<=0, PCResult<=target, next state REQ.
REQ-024 Redirect in REQ with IMemAck=0: target latched into an internal pending register and the outstanding fetch continues at the old address; a later redirect before the ack overwrites the pending target.
REQ-025 REQ with IMemAck=1 and a pending or same-cycle redirect: IMemData discarded, PCResult<=target (same-cycle redirect wins over pending), pending cleared, state stays REQ; InstrValid stays 0.
REQ-026 Redirect in IDLE: PCResult<=target, then transition to REQ as normal.
REQ-027 PC wrap-around follows PCAddResult unmodified (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 IMemAck is ignored in IDLE and HOLD.
REQ-029 PCResult changes only on reset, on a redirect load, or on consumption in HOLD.

Reset
REQ-030 Reset=1: PCResult<=RESET_PC, state<=IDLE, IMemReq=0, InstrValid<=0, Instruction<=0, pending redirect cleared.
REQ-031 Reset has priority over all other inputs, including a same-cycle IMemAck or redirect.
REQ-032 Reset during REQ abandons the outstanding fetch; a late IMemAck after reset is ignored per REQ-028.

Verification
REQ-033 Reset, then IMemAck one cycle after IMemReq with data 32'h2008_0005, Stall=0, PCAddResult=PC+4 -> PC sequence 0, 4, 8; InstrValid high one cycle per fetch.
REQ-034 HOLD with Stall=1 for 3 cycles -> PCResult, Instruction and InstrValid constant; Stall=0 -> next cycle PCResult=PCAddResult, state REQ.
REQ-035 HOLD with Jump=1, JumpTarget=32'h0000_0403 and BranchTaken=1 in the same cycle -> PCResult=32'h0000_0400, InstrValid=0, IMemReq=1 next cycle.
REQ-036 REQ at PC=32'h10, BranchTaken=1, BranchTarget=32'h40, IMemAck 2 cycles later -> IMemAddr stays 32'h10 until ack, data discarded, then IMemAddr=32'h40.
REQ-037 Reset asserted in REQ with IMemAck=1 in the same cycle -> PCResult=RESET_PC, InstrValid=0, IMemReq=0 next cycle; IMemReq returns high one cycle after Reset drops.
REQ-038 PCResult=32'hFFFF_FFFC consumed with PCAddResult=32'h0 -> PCResult=32'h0, fetch issued at 32'h0.
